// File: rtl/cpu_ibus_axi_bridge.sv
// cpu_ibus_axi_bridge: single-outstanding bridge from the instruction-fetch bus to an AXI read channel.
// Revision: 1.0
`default_nettype none

module cpu_ibus_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ibus_addr,
  input  logic        ibus_read,
  output logic [31:0] ibus_rdata,
  output logic        ibus_valid,
  output logic [31:0] ibus_resp_addr,
  output logic        ibus_err,
  output logic        ibus_stall_req,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // With arlen=0 every accepted beat is the last one, so rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (ibus_read) begin
          req_addr_d = ibus_addr;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (arready) state_d = DATA;
      end
      DATA: begin
        if (rvalid && (rid == AXI_ID)) begin
          rdata_d = rdata;
          err_d   = rresp[1];
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are forced low while reset is held, before the state register has cleared.
  assign arvalid        = !reset && (state_q == ADDR);
  assign rready         = !reset && (state_q == DATA);
  assign ibus_valid     = !reset && (state_q == RESP);
  assign ibus_err       = ibus_valid && err_q;
  assign ibus_stall_req = !reset && (((state_q == IDLE) && ibus_read) ||
                                     (state_q == ADDR) || (state_q == DATA));

  assign ibus_rdata     = rdata_q;
  assign ibus_resp_addr = req_addr_q;
  assign araddr         = req_addr_q;
  assign arid           = AXI_ID;
  assign arlen          = 4'h0;
  assign arsize         = 3'b010;
  assign arburst        = 2'b01;

endmodule

`default_nettype wire

// File: tb/tb_cpu_ibus_axi_bridge.sv
// tb_cpu_ibus_axi_bridge: directed per-cycle vectors plus hand-written backpressure and reset sequences.
// Revision: 1.0
`default_nettype none

module tb_cpu_ibus_axi_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ibus_addr;
  logic        ibus_read;
  logic [31:0] ibus_rdata;
  logic        ibus_valid;
  logic [31:0] ibus_resp_addr;
  logic        ibus_err;
  logic        ibus_stall_req;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 clock = ~clock;

  cpu_ibus_axi_bridge #(.AXI_ID(4'h0)) dut (
    .clock(clock), .reset(reset),
    .ibus_addr(ibus_addr), .ibus_read(ibus_read),
    .ibus_rdata(ibus_rdata), .ibus_valid(ibus_valid),
    .ibus_resp_addr(ibus_resp_addr), .ibus_err(ibus_err),
    .ibus_stall_req(ibus_stall_req),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic        arr;
    logic        rv;
    logic [3:0]  rid;
    logic [31:0] rdat;
    logic [1:0]  rresp;
    logic        rlast;
    logic        e_arv;
    logic [31:0] e_araddr;
    logic        e_rrdy;
    logic        e_val;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_raddr;
    logic        e_stall;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // One bus cycle: drive inputs just after the rising edge, then let outputs settle.
  task automatic cyc(input logic rd, input logic [31:0] addr, input logic arr,
                     input logic rv, input logic [3:0] id, input logic [31:0] dat,
                     input logic [1:0] rsp, input logic lst);
    @(posedge clock);
    #1;
    ibus_read = rd; ibus_addr = addr; arready = arr;
    rvalid = rv; rid = id; rdata = dat; rresp = rsp; rlast = lst;
    #2;
  endtask

  initial begin
    //            rd addr          arr rv rid   rdat          rsp   lst  arv araddr        rrdy val err rdata         raddr         stall
    vecs[0]  = '{1, 32'hBFC00000, 0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[1]  = '{0, 32'h0,        1, 0, 4'h0, 32'h0,        2'b00, 0,  1, 32'hBFC00000, 0,   0,  0,  32'h0,        32'h0,        1};
    vecs[2]  = '{0, 32'h0,        0, 1, 4'h0, 32'h3C080001, 2'b00, 1,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[3]  = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   1,  0,  32'h3C080001, 32'hBFC00000, 0};
    vecs[4]  = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        0};
    // error response; address change while in ADDR must be ignored
    vecs[5]  = '{1, 32'h00001000, 0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[6]  = '{1, 32'hFFFF0000, 1, 0, 4'h0, 32'h0,        2'b00, 0,  1, 32'h00001000, 0,   0,  0,  32'h0,        32'h0,        1};
    vecs[7]  = '{0, 32'h0,        0, 1, 4'h0, 32'hDEADBEEF, 2'b10, 1,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[8]  = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   1,  1,  32'hDEADBEEF, 32'h00001000, 0};
    // foreign ID beat ignored; real beat has rlast=0 and EXOKAY
    vecs[9]  = '{1, 32'h00000400, 0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[10] = '{0, 32'h0,        1, 0, 4'h0, 32'h0,        2'b00, 0,  1, 32'h00000400, 0,   0,  0,  32'h0,        32'h0,        1};
    vecs[11] = '{0, 32'h0,        0, 1, 4'h1, 32'h11111111, 2'b00, 1,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[12] = '{0, 32'h0,        0, 1, 4'h0, 32'h00000020, 2'b01, 0,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[13] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   1,  0,  32'h00000020, 32'h00000400, 0};
    // back-to-back fetches 0x0, 0x4, 0x8
    vecs[14] = '{1, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[15] = '{1, 32'h0,        1, 0, 4'h0, 32'h0,        2'b00, 0,  1, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[16] = '{1, 32'h0,        0, 1, 4'h0, 32'h000000A0, 2'b00, 1,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[17] = '{1, 32'h4,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   1,  0,  32'h000000A0, 32'h0,        0};
    vecs[18] = '{1, 32'h4,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[19] = '{1, 32'h4,        1, 0, 4'h0, 32'h0,        2'b00, 0,  1, 32'h4,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[20] = '{1, 32'h4,        0, 1, 4'h0, 32'h000000A4, 2'b00, 1,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[21] = '{1, 32'h8,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   1,  0,  32'h000000A4, 32'h4,        0};
    vecs[22] = '{1, 32'h8,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[23] = '{1, 32'h8,        1, 0, 4'h0, 32'h0,        2'b00, 0,  1, 32'h8,        0,   0,  0,  32'h0,        32'h0,        1};
    vecs[24] = '{1, 32'h8,        0, 1, 4'h0, 32'h000000A8, 2'b00, 1,  0, 32'h0,        1,   0,  0,  32'h0,        32'h0,        1};
    vecs[25] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   1,  0,  32'h000000A8, 32'h8,        0};
    vecs[26] = '{0, 32'h0,        0, 0, 4'h0, 32'h0,        2'b00, 0,  0, 32'h0,        0,   0,  0,  32'h0,        32'h0,        0};

    // Reset with a fetch request pending: stall must still be low.
    reset = 1'b1; ibus_read = 1'b1; ibus_addr = 32'h12345678; arready = 1'b0;
    rvalid = 1'b0; rid = 4'h0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_valid", ibus_valid, 0);
    chk("rst_err", ibus_err, 0);
    chk("rst_rdata", ibus_rdata, 0);
    chk("rst_resp_addr", ibus_resp_addr, 0);
    chk("rst_stall", ibus_stall_req, 0);
    chk("arid", arid, 4'h0);
    chk("arlen", arlen, 4'h0);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);
    ibus_read = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].rd, vecs[i].addr, vecs[i].arr, vecs[i].rv, vecs[i].rid,
          vecs[i].rdat, vecs[i].rresp, vecs[i].rlast);
      chk($sformatf("v%0d_arvalid", i), arvalid, vecs[i].e_arv);
      if (vecs[i].e_arv) chk($sformatf("v%0d_araddr", i), araddr, vecs[i].e_araddr);
      chk($sformatf("v%0d_rready", i), rready, vecs[i].e_rrdy);
      chk($sformatf("v%0d_valid", i), ibus_valid, vecs[i].e_val);
      if (vecs[i].e_val) begin
        chk($sformatf("v%0d_err", i), ibus_err, vecs[i].e_err);
        chk($sformatf("v%0d_rdata", i), ibus_rdata, vecs[i].e_rdata);
        chk($sformatf("v%0d_resp_addr", i), ibus_resp_addr, vecs[i].e_raddr);
      end
      chk($sformatf("v%0d_stall", i), ibus_stall_req, vecs[i].e_stall);
    end

    // Backpressure: arready low for five cycles.
    cyc(1, 32'h00002000, 0, 0, 4'h0, 32'h0, 2'b00, 0);
    chk("bp_req_stall", ibus_stall_req, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 32'h00002000, 0, 0, 4'h0, 32'h0, 2'b00, 0);
      chk($sformatf("bp%0d_arvalid", k), arvalid, 1);
      chk($sformatf("bp%0d_araddr", k), araddr, 32'h00002000);
      chk($sformatf("bp%0d_stall", k), ibus_stall_req, 1);
      chk($sformatf("bp%0d_valid", k), ibus_valid, 0);
    end
    cyc(1, 32'h00002000, 1, 0, 4'h0, 32'h0, 2'b00, 0);
    chk("bp_hs_arvalid", arvalid, 1);
    cyc(1, 32'h00002000, 0, 1, 4'h0, 32'h00001234, 2'b00, 1);
    chk("bp_data_arvalid", arvalid, 0);
    chk("bp_data_valid", ibus_valid, 0);
    cyc(0, 32'h0, 0, 0, 4'h0, 32'h0, 2'b00, 0);
    chk("bp_resp_valid", ibus_valid, 1);
    chk("bp_resp_rdata", ibus_rdata, 32'h00001234);
    chk("bp_resp_addr", ibus_resp_addr, 32'h00002000);

    // Reset while waiting in DATA, then an R beat arrives afterwards.
    cyc(1, 32'h00003000, 0, 0, 4'h0, 32'h0, 2'b00, 0);
    cyc(1, 32'h00003000, 1, 0, 4'h0, 32'h0, 2'b00, 0);
    cyc(1, 32'h00003000, 0, 0, 4'h0, 32'h0, 2'b00, 0);
    chk("rd_data_rready", rready, 1);
    @(posedge clock);
    #1 reset = 1'b1; ibus_read = 1'b0; rvalid = 1'b1; rid = 4'h0; rdata = 32'h00000055; rlast = 1'b1;
    #2;
    chk("rd_rst_rready", rready, 0);
    chk("rd_rst_stall", ibus_stall_req, 0);
    cyc(0, 32'h0, 0, 1, 4'h0, 32'h00000055, 2'b10, 1);
    chk("rd_rst2_rdata", ibus_rdata, 0);
    chk("rd_rst2_resp_addr", ibus_resp_addr, 0);
    chk("rd_rst2_valid", ibus_valid, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    #2;
    chk("rd_post_rready", rready, 0);
    chk("rd_post_stall", ibus_stall_req, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 32'h0, 0, 1, 4'h0, 32'h00000055, 2'b10, 1);
      chk($sformatf("rd_post%0d_valid", k), ibus_valid, 0);
      chk($sformatf("rd_post%0d_rready", k), rready, 0);
      chk($sformatf("rd_post%0d_rdata", k), ibus_rdata, 0);
      chk($sformatf("rd_post%0d_err", k), ibus_err, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
